// File: rtl/button_event_arbiter.sv
// button_event_arbiter
// Collects single-cycle event pulses (one bit per field), holds each as a
// pending request and serialises them round-robin onto a valid/ready event
// stream. A pulse that arrives while its field is already pending coalesces
// with it and sets a sticky per-field overflow flag, so no event is lost
// without trace. All outputs are registered.
module button_event_arbiter #(
    parameter int FIELDS = 4,
    localparam int IDX_W = (FIELDS > 1) ? $clog2(FIELDS) : 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [FIELDS-1:0] pulses_in,
    input  logic              enable_in,
    input  logic              clear_in,
    output logic              event_valid_out,
    input  logic              event_ready_in,
    output logic [IDX_W-1:0]  event_idx_out,
    output logic [FIELDS-1:0] pending_out,
    output logic [FIELDS-1:0] overflow_out
);

    // Round-robin pointer: the field the next grant scan starts from.
    logic [IDX_W-1:0]  ptr;

    logic              slot_free;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  ptr_next;
    logic              do_grant;
    logic [FIELDS-1:0] new_pulses;
    logic [FIELDS-1:0] granted_mask;
    logic [FIELDS-1:0] pending_next;
    logic [FIELDS-1:0] overflow_next;

    // Lowest-index candidates at/after the pointer and anywhere; together
    // they implement a circular scan ptr, ptr+1, ... without modulo indexing.
    logic              hi_hit;
    logic [IDX_W-1:0]  hi_idx;
    logic              lo_hit;
    logic [IDX_W-1:0]  lo_idx;

    assign slot_free  = !event_valid_out || event_ready_in;
    assign new_pulses = enable_in ? pulses_in : '0;

    // Rotating-priority grant selection starting at ptr.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first,
        // otherwise any path that skips an assignment infers a latch.
        hi_hit = 1'b0;
        hi_idx = '0;
        lo_hit = 1'b0;
        lo_idx = '0;
        // Descending scan: the last hit written is the lowest matching index.
        for (int i = FIELDS - 1; i >= 0; i--) begin
            if (pending_out[i]) begin
                lo_hit = 1'b1;
                lo_idx = IDX_W'(i);
                if (IDX_W'(i) >= ptr) begin
                    hi_hit = 1'b1;
                    hi_idx = IDX_W'(i);
                end
            end
        end
        grant_valid = lo_hit;
        grant_idx   = hi_hit ? hi_idx : lo_idx;
        ptr_next    = (grant_idx == IDX_W'(FIELDS - 1)) ? '0 : grant_idx + IDX_W'(1);
    end

    assign do_grant = slot_free && grant_valid;

    // Pending/overflow update: granted bit clears, a new pulse re-arms it, and
    // a pulse onto a pending bit that is not being granted counts as overflow.
    always_comb begin
        granted_mask = '0;
        for (int i = 0; i < FIELDS; i++) begin
            granted_mask[i] = do_grant && (grant_idx == IDX_W'(i));
        end
        pending_next  = (pending_out & ~granted_mask) | new_pulses;
        overflow_next = overflow_out | (new_pulses & pending_out & ~granted_mask);
    end

    // State registers: reset beats clear, clear beats normal operation.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_in) begin
            event_valid_out <= 1'b0;
            event_idx_out   <= '0;
            pending_out     <= '0;
            overflow_out    <= '0;
            ptr             <= '0;
        end else if (clear_in) begin
            // Pointer and last index deliberately survive a flush.
            event_valid_out <= 1'b0;
            pending_out     <= '0;
            overflow_out    <= '0;
        end else begin
            pending_out  <= pending_next;
            overflow_out <= overflow_next;
            if (slot_free) begin
                event_valid_out <= grant_valid;
                if (grant_valid) begin
                    event_idx_out <= grant_idx;
                    ptr           <= ptr_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed testbench for button_event_arbiter with an event scoreboard:
// expected indices are queued when pulses are driven and compared when the
// DUT hands an event over (valid & ready at a clock edge).
module tb_button_event_arbiter;

    localparam int FIELDS = 4;
    localparam int IDX_W  = 2;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [FIELDS-1:0] pulses_in;
    logic              enable_in;
    logic              clear_in;
    logic              event_valid_out;
    logic              event_ready_in;
    logic [IDX_W-1:0]  event_idx_out;
    logic [FIELDS-1:0] pending_out;
    logic [FIELDS-1:0] overflow_out;

    int checks = 0;
    int errors = 0;
    int sb_q[$];

    button_event_arbiter #(.FIELDS(FIELDS)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .pulses_in       (pulses_in),
        .enable_in       (enable_in),
        .clear_in        (clear_in),
        .event_valid_out (event_valid_out),
        .event_ready_in  (event_ready_in),
        .event_idx_out   (event_idx_out),
        .pending_out     (pending_out),
        .overflow_out    (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs are already stable, so a handshake is judged on the
    // values the edge will see; then move to 1 time unit after the edge.
    task automatic tick();
        int exp_idx;
        if (event_valid_out && event_ready_in) begin
            exp_idx = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD;
            check("event_idx", 32'(event_idx_out), 32'(exp_idx));
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic pulse(input logic [FIELDS-1:0] bits);
        pulses_in = bits;
        tick();
        pulses_in = '0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        pulses_in      = '0;
        enable_in      = 1'b1;
        clear_in       = 1'b0;
        event_ready_in = 1'b1;
        rst_in         = 1'b1;
        #1;
        do_reset();

        // Reset state
        check("rst_valid",    32'(event_valid_out), 32'd0);
        check("rst_idx",      32'(event_idx_out),   32'd0);
        check("rst_pending",  32'(pending_out),     32'd0);
        check("rst_overflow", 32'(overflow_out),    32'd0);

        // T1: single pulse on field 2, valid for exactly one cycle
        sb_q.push_back(2);
        pulse(4'b0100);
        check("t1_pending_captured", 32'(pending_out), 32'h4);
        check("t1_valid_before",     32'(event_valid_out), 32'd0);
        tick();
        check("t1_valid",   32'(event_valid_out), 32'd1);
        check("t1_idx",     32'(event_idx_out),   32'd2);
        check("t1_pending", 32'(pending_out),     32'd0);
        tick();
        check("t1_valid_drop", 32'(event_valid_out), 32'd0);
        check("t1_overflow",   32'(overflow_out),    32'd0);
        check("t1_sb_empty",   32'(sb_q.size()),     32'd0);

        // T2: 1011 from ptr 0 -> 0,1,3 back to back
        do_reset();
        sb_q.push_back(0);
        sb_q.push_back(1);
        sb_q.push_back(3);
        pulse(4'b1011);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_valid_run", 32'(event_valid_out), 32'd1);
        end
        tick();
        check("t2_valid_drop", 32'(event_valid_out), 32'd0);
        check("t2_sb_empty",   32'(sb_q.size()),     32'd0);

        // T3: after granting 1, pulses 0101 -> 2 then 0
        sb_q.push_back(1);
        pulse(4'b0010);
        drain(2);
        sb_q.push_back(2);
        sb_q.push_back(0);
        pulse(4'b0101);
        drain(4);
        check("t3_valid_drop", 32'(event_valid_out), 32'd0);
        check("t3_sb_empty",   32'(sb_q.size()),     32'd0);

        // T4: backpressure, field 1 pulsed three times 3 cycles apart
        event_ready_in = 1'b0;
        sb_q.push_back(1);
        pulse(4'b0010);
        drain(2);
        sb_q.push_back(1);
        pulse(4'b0010);
        check("t4_hold_idx",   32'(event_idx_out), 32'd1);
        check("t4_no_ovf_yet", 32'(overflow_out),  32'd0);
        drain(2);
        pulse(4'b0010);
        check("t4_valid",    32'(event_valid_out), 32'd1);
        check("t4_idx",      32'(event_idx_out),   32'd1);
        check("t4_pending",  32'(pending_out),     32'h2);
        check("t4_overflow", 32'(overflow_out),    32'h2);
        event_ready_in = 1'b1;
        drain(2);
        check("t4_valid_drop",   32'(event_valid_out), 32'd0);
        check("t4_overflow_sticky", 32'(overflow_out), 32'h2);
        check("t4_sb_empty",     32'(sb_q.size()),     32'd0);

        // T5: clear while slot held and 0110 pending; pulse[3] discarded
        event_ready_in = 1'b0;
        pulse(4'b1000);
        tick();
        pulse(4'b0110);
        check("t5_valid_held", 32'(event_valid_out), 32'd1);
        check("t5_pending",    32'(pending_out),     32'h6);
        clear_in  = 1'b1;
        pulses_in = 4'b1000;
        tick();
        clear_in  = 1'b0;
        pulses_in = '0;
        check("t5_valid_cleared",    32'(event_valid_out), 32'd0);
        check("t5_pending_cleared",  32'(pending_out),     32'd0);
        check("t5_overflow_cleared", 32'(overflow_out),    32'd0);
        event_ready_in = 1'b1;
        drain(4);
        check("t5_no_event", 32'(event_valid_out), 32'd0);

        // T6: disabled pulses ignored
        enable_in = 1'b0;
        pulse(4'b1111);
        check("t6_pending", 32'(pending_out), 32'd0);
        drain(3);
        check("t6_no_event", 32'(event_valid_out), 32'd0);
        enable_in = 1'b1;

        // T6b: reset during backpressure, then scan restarts at 0
        event_ready_in = 1'b0;
        pulse(4'b0100);
        tick();
        pulse(4'b0100);
        pulse(4'b0100);
        check("t6_pre_rst_overflow", 32'(overflow_out), 32'h4);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("t6_rst_valid",    32'(event_valid_out), 32'd0);
        check("t6_rst_idx",      32'(event_idx_out),   32'd0);
        check("t6_rst_pending",  32'(pending_out),     32'd0);
        check("t6_rst_overflow", 32'(overflow_out),    32'd0);
        event_ready_in = 1'b1;
        sb_q.push_back(0);
        sb_q.push_back(3);
        pulse(4'b1001);
        drain(3);
        check("t6_valid_drop", 32'(event_valid_out), 32'd0);
        check("t6_sb_empty",   32'(sb_q.size()),     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
